// File: rtl/alu_issue_queue.sv
// alu_issue_queue
// ---------------
// Buffers ALU commands in an in-order FIFO and issues them one at a time
// to an external combinational ALU. The ALU result is captured one cycle
// after issue and then held as a response until downstream accepts it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (cmd_a, cmd_b, cmd_mode, cmd_op)
//   alu_a/b/mode/op   registered operands and selectors driving the ALU
//   alu_res, alu_err  combinational ALU result and divide-by-zero flag
//   rsp_valid/ready   response handshake (rsp_res, rsp_err)
//   err_sticky        set by any captured error, cleared by err_clr
//   done_count        delivered responses, modulo 256
//   dbg_state         current FSM state (0 idle, 1 exec, 2 resp)
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. The sender holds valid and its payload until that edge;
// ready may change freely and never depends on valid within the block.

module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_mode,
    input  logic [1:0]  cmd_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_mode,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic        alu_err,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_res,
    output logic        rsp_err,
    output logic        err_sticky,
    input  logic        err_clr,
    output logic [7:0]  done_count,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    // FIFO storage: {a, b, mode, op}
    logic [34:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          push, pop, capture;
    logic [34:0]   head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Held low during reset so nothing is accepted while the block is cleared.
    assign cmd_ready = rst_n && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign dbg_state = state;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (!empty) state_nx = S_EXEC;
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nx = empty ? S_IDLE : S_EXEC;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A pop loads the ALU registers directly, either from idle or as the
    // current response retires, giving one response every two cycles.
    always_comb begin
        rsp_valid = 1'b0;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: pop = !empty;
            S_EXEC: capture = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                pop       = rsp_ready && !empty;
            end
            default: ;
        endcase
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_a, cmd_b, cmd_mode, cmd_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- ALU operand registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= 1'b0;
            alu_op   <= '0;
        end else if (pop) begin
            alu_a    <= head[34:19];
            alu_b    <= head[18:3];
            alu_mode <= head[2];
            alu_op   <= head[1:0];
        end
    end

    // ---------------- Response capture and status ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_res    <= '0;
            rsp_err    <= 1'b0;
            err_sticky <= 1'b0;
            done_count <= '0;
        end else begin
            if (capture) begin
                rsp_res <= alu_res;
                rsp_err <= alu_err;
            end
            // A new error wins over a clear arriving on the same edge.
            if (capture && alu_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                done_count <= done_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_mode;
    logic [1:0]  cmd_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_mode;
    logic [1:0]  alu_op;
    logic [31:0] alu_res;
    logic        alu_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_err;
    logic        err_sticky;
    logic        err_clr;
    logic [7:0]  done_count;
    logic [1:0]  dbg_state;

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_op(alu_op),
        .alu_res(alu_res), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .err_sticky(err_sticky), .err_clr(err_clr),
        .done_count(done_count), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- reference ALU ----------------
    // Logic ops yield a zero-extended 16-bit value; math ops are signed and
    // sign-extended to 32 bits; divide by zero flags an error with result 0.
    function automatic logic [32:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic mode, input logic [1:0] op);
        logic signed [31:0] sa, sb, r;
        logic e;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        r  = '0;
        e  = 1'b0;
        if (!mode) begin
            case (op)
                2'd0: r = {16'h0, a & b};
                2'd1: r = {16'h0, a | b};
                2'd2: r = {16'h0, a ^ b};
                default: r = {16'h0, ~a};
            endcase
        end else begin
            case (op)
                2'd0: r = sa + sb;
                2'd1: r = sa - sb;
                2'd2: r = sa * sb;
                default: begin
                    if (sb == 0) e = 1'b1;
                    else r = sa / sb;
                end
            endcase
        end
        return {e, r};
    endfunction

    always_comb {alu_err, alu_res} = alu_model(alu_a, alu_b, alu_mode, alu_op);

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];
    int          hs_times[$];
    int          hs_cnt = 0;
    logic [7:0]  done_exp = 8'd0;
    logic        held = 1'b0;
    logic [32:0] held_val;
    logic [32:0] mon_e;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got %0h expected no response", {rsp_err, rsp_res});
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("rsp", {rsp_err, rsp_res}, mon_e);
                    end
                    check("done_count", {25'd0, done_count}, {25'd0, done_exp});
                    done_exp = done_exp + 8'd1;
                    hs_cnt++;
                    hs_times.push_back(cyc);
                    held = 1'b0;
                end else begin
                    if (held) check("stall_stable", {rsp_err, rsp_res}, held_val);
                    held     = 1'b1;
                    held_val = {rsp_err, rsp_res};
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic mode,
                            input logic [1:0] op, input logic [32:0] exp,
                            input int max_wait, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_mode = mode; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            if (cmd_ready) begin
                exp_q.push_back(exp);
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic set_rsp_ready(input logic v);
        @(posedge clk);
        #1 rsp_ready = v;
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic wait_rsp_valid(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #2;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_valid_seen", {32'd0, seen}, 33'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, {32'd0, cmd_ready}, 33'd0);
        check({tag, "_rsp_valid"}, {32'd0, rsp_valid}, 33'd0);
        check({tag, "_rsp"}, {rsp_err, rsp_res}, 33'd0);
        check({tag, "_alu_ab"}, {1'b0, alu_a, alu_b}, 33'd0);
        check({tag, "_alu_sel"}, {30'd0, alu_mode, alu_op}, 33'd0);
        check({tag, "_err_sticky"}, {32'd0, err_sticky}, 33'd0);
        check({tag, "_done_count"}, {25'd0, done_count}, 33'd0);
        check({tag, "_state"}, {31'd0, dbg_state}, 33'd0);
    endtask

    // ---------------- stimulus ----------------
    bit ok;
    int accepted;
    int vcount;
    bit rand_run;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = 1'b0;
        cmd_op = '0; rsp_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2 check_reset_values("init");
        @(negedge clk) rst_n = 1'b1;
        #1 check("post_reset_cmd_ready", {32'd0, cmd_ready}, 33'd1);

        // Single add and its latency: push at edge E, response visible after E+2
        // and handshaken at E+3.
        set_rsp_ready(1'b1);
        send_cmd(16'd32, 16'd27, 1'b1, 2'd0, {1'b0, 32'd59}, 10, ok);
        @(negedge clk) check("lat_e0", {32'd0, rsp_valid}, 33'd0);
        @(negedge clk) check("lat_e1", {32'd0, rsp_valid}, 33'd0);
        @(negedge clk) check("lat_e2", {32'd0, rsp_valid}, 33'd1);
        check("add_res", {1'b0, rsp_res}, {1'b0, 32'd59});
        drain(20);
        check("add_done_count", {25'd0, done_count}, 33'd1);

        // Divide by zero, sticky error and clear.
        send_cmd(16'd100, 16'd0, 1'b1, 2'd3, {1'b1, 32'd0}, 10, ok);
        drain(20);
        check("div0_sticky", {32'd0, err_sticky}, 33'd1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("sticky_cleared", {32'd0, err_sticky}, 33'd0);
        // Hold err_clr across the capture edge of a new error.
        send_cmd(16'd7, 16'd0, 1'b1, 2'd3, {1'b1, 32'd0}, 10, ok);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk);
        @(negedge clk) err_clr = 1'b0;
        check("sticky_set_wins", {32'd0, err_sticky}, 33'd1);
        drain(20);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;

        // Backpressure: DEPTH + 1 commands fit with downstream stalled.
        set_rsp_ready(1'b0);
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            logic m;
            logic [1:0] o;
            a = 16'($urandom); b = 16'($urandom_range(1, 65535));
            m = 1'($urandom); o = 2'($urandom);
            send_cmd(a, b, m, o, alu_model(a, b, m, o), (i < 5) ? 8 : 4, ok);
            if (ok) accepted++;
        end
        check("bp_accepted", 33'(accepted), 33'd5);
        @(negedge clk) check("bp_cmd_ready_low", {32'd0, cmd_ready}, 33'd0);
        repeat (4) @(posedge clk);
        set_rsp_ready(1'b1);
        drain(40);

        // Back-to-back: queue four, then release; responses two cycles apart.
        set_rsp_ready(1'b0);
        send_cmd(16'd81, 16'hFFE9, 1'b1, 2'd1, {1'b0, 32'd104}, 10, ok);
        send_cmd(16'hFFD6, 16'd102, 1'b1, 2'd2, {1'b0, 32'hFFFF_EF44}, 10, ok);
        send_cmd(16'h00FF, 16'h0F0F, 1'b0, 2'd0, {1'b0, 32'h0000_000F}, 10, ok);
        send_cmd(16'h0000, 16'h0000, 1'b0, 2'd3, {1'b0, 32'h0000_FFFF}, 10, ok);
        wait_rsp_valid(20);
        hs_times.delete();
        set_rsp_ready(1'b1);
        drain(40);
        check("b2b_count", 33'(hs_times.size()), 33'd4);
        if (hs_times.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_gap", 33'(hs_times[i] - hs_times[i-1]), 33'd2);
            end
        end

        // Reset mid-operation: one response held, three queued.
        set_rsp_ready(1'b0);
        for (int i = 0; i < 4; i++) begin
            send_cmd(16'(i + 1), 16'd3, 1'b1, 2'd0, {1'b0, 32'(i + 4)}, 10, ok);
        end
        wait_rsp_valid(20);
        #3 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        exp_q.delete();
        done_exp = 8'd0;
        hs_cnt   = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        check("no_stale_rsp", 33'(vcount), 33'd0);
        check("midrst_cmd_ready", {32'd0, cmd_ready}, 33'd1);

        // Random traffic: exactly 256 responses since reset wraps done_count.
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    logic [15:0] a, b;
                    logic m;
                    logic [1:0] o;
                    a = 16'($urandom);
                    b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
                    m = 1'($urandom); o = 2'($urandom);
                    send_cmd(a, b, m, o, alu_model(a, b, m, o), 60, ok);
                    if (!ok) begin
                        total++;
                        bad++;
                        $display("FAIL rand_accept_timeout: got no accept expected accept at cmd %0d", i);
                    end
                end
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1 rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        set_rsp_ready(1'b1);
        drain(200);
        check("wrap_hs_cnt", 33'(hs_cnt), 33'd256);
        check("wrap_done_count", {25'd0, done_count}, 33'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
